// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory
// and registers the fetched word into the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned IMEM_DEPTH = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [PC_WIDTH-1:0] ifid_pc,
  output logic [31:0]         ifid_instr,
  output logic                ifid_valid,
  output logic                fetch_fault,
  output logic [15:0]         fetch_count
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] LAST_W = PC_WIDTH'(IMEM_DEPTH - 1);
  localparam logic [PC_WIDTH-1:0] DEPTH  = PC_WIDTH'(IMEM_DEPTH);
  localparam logic [15:0]         CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic                valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc: '0, instr: 32'h0, valid: 1'b0};

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  ifid_t               ifid_q, ifid_d;
  logic                fault_q, fault_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [PC_WIDTH-1:0] next_pc;
  logic                target_ok;

  assign next_pc   = (pc_q == LAST_W) ? '0 : pc_q + 1'b1;
  assign target_ok = branch_target < DEPTH;

  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      ifid_d = BUBBLE;
      if (target_ok) begin
        pc_d = branch_target;
      end else begin
        // Bad target: restart from the reset vector and latch the fault.
        pc_d    = RST_PC;
        fault_d = 1'b1;
      end
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (flush) begin
      ifid_d = BUBBLE;
      pc_d   = next_pc;
    end else begin
      ifid_d.pc    = pc_q;
      ifid_d.instr = imem_data;
      ifid_d.valid = 1'b1;
      pc_d         = next_pc;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RST_PC;
      ifid_q  <= BUBBLE;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_fault = fault_q;
  assign fetch_count = cnt_q;

endmodule
